led_bank_sched: RTL and testbench

- Time-multiplexed scheduler for the shared 4-bit VAL bus that feeds the SUB instance arrays driving the LED banks.
- Up to NBANK requesters (banks) each present a W-bit value and a request.
- The block round-robin grants one bank at a time, drives VAL and a one-hot bank enable for a fixed dwell, blanks the bus between grants, then acknowledges.
- It sits between bank-level control logic and the SUB/AND array netlist.

---
 rtl/led_sched_pkg.sv | 43 ++++
 rtl/rr_arbiter.sv | 33 +++
 rtl/led_bank_sched.sv | 110 +++++++++++
 tb/tb_led_bank_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED bank VAL-bus scheduler.
// Holds the state encoding, default sizing and the round-robin pick.
package led_sched_pkg;

  localparam int NBANK_D = 4;
  localparam int W_D     = 4;
  localparam int DWELL_D = 8;
  localparam int GAP_D   = 1;

  localparam int MAXN = 8;
  localparam int IDXW = 3;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    BLANK
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [IDXW-1:0] idx;
  } pick_t;

  // First requester at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(
    input logic [MAXN-1:0] req,
    input logic [IDXW-1:0] ptr,
    input int              n
  );
    pick_t p;
    int    k;
    p = '0;
    for (int i = 0; i < MAXN; i++) begin
      k = (int'(ptr) + i) % n;
      if (i < n && !p.valid && req[k[IDXW-1:0]]) begin
        p.valid = 1'b1;
        p.idx   = k[IDXW-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over NBANK requesters with a registered pointer.
// The pointer moves past the winner whenever advance is pulsed.
import led_sched_pkg::*;

module rr_arbiter #(
  parameter int NBANK = NBANK_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBANK-1:0] req,
  input  logic             advance,
  output logic [IDXW-1:0]  sel,
  output logic             valid,
  output logic [IDXW-1:0]  ptr
);

  logic [MAXN-1:0] req_x;
  pick_t           pick;

  assign req_x = MAXN'(req);
  assign pick  = rr_pick(req_x, ptr, NBANK);
  assign sel   = pick.idx;
  assign valid = pick.valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (sel == IDXW'(NBANK - 1)) ? '0 : sel + 1'b1;
    end
  end

endmodule

// File: rtl/led_bank_sched.sv
// Time-multiplexes the shared VAL bus across LED banks: grant, dwell,
// blank, acknowledge. All outputs come straight from flops.
import led_sched_pkg::*;

module led_bank_sched #(
  parameter int NBANK = NBANK_D,
  parameter int W     = W_D,
  parameter int DWELL = DWELL_D,
  parameter int GAP   = GAP_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NBANK-1:0]   req,
  input  logic [NBANK*W-1:0] data,
  output logic [W-1:0]       val_out,
  output logic [NBANK-1:0]   bank_en,
  output logic [NBANK-1:0]   grant,
  output logic [NBANK-1:0]   ack,
  output logic               busy
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [GW-1:0]   gcnt, gcnt_d;
  logic [W-1:0]    val_d;
  logic [NBANK-1:0] en_d, ack_d, one;
  logic            busy_d;
  logic            adv, valid, held;
  logic [IDXW-1:0] sel, ptr;
  logic [W-1:0]    data_sel;

  rr_arbiter #(.NBANK(NBANK)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (adv),
    .sel     (sel),
    .valid   (valid),
    .ptr     (ptr)
  );

  assign data_sel = data[int'(sel)*W +: W];
  assign one      = NBANK'(1) << sel;
  assign held     = |(req & bank_en);
  assign grant    = bank_en;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    gcnt_d  = gcnt;
    val_d   = val_out;
    en_d    = bank_en;
    ack_d   = '0;
    adv     = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && valid) begin
          state_d = HOLD;
          val_d   = data_sel;
          en_d    = one;
          cnt_d   = CW'(DWELL - 1);
          adv     = 1'b1;
        end
      end
      HOLD: begin
        if (!enable || !held || cnt == '0) begin
          // Only a completed dwell with the request still up is acked.
          if (enable && held) ack_d = bank_en;
          val_d   = '0;
          en_d    = '0;
          gcnt_d  = GW'(GAP > 0 ? GAP - 1 : 0);
          state_d = (GAP == 0) ? IDLE : BLANK;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      BLANK: begin
        if (gcnt == '0) state_d = IDLE;
        else gcnt_d = gcnt - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      gcnt    <= '0;
      val_out <= '0;
      bank_en <= '0;
      ack     <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      gcnt    <= gcnt_d;
      val_out <= val_d;
      bank_en <= en_d;
      ack     <= ack_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_led_bank_sched.sv
// Directed bench for led_bank_sched: default build plus a GAP=0 build.
module tb_led_bank_sched;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [3:0]  req;
  logic [15:0] data;
  logic [3:0]  val_out, bank_en, grant, ack;
  logic        busy;

  logic        b_enable;
  logic [3:0]  b_req;
  logic [15:0] b_data;
  logic [3:0]  b_val, b_en, b_grant, b_ack;
  logic        b_busy;

  int checks;
  int errors;

  led_bank_sched dut_a (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .req     (req),
    .data    (data),
    .val_out (val_out),
    .bank_en (bank_en),
    .grant   (grant),
    .ack     (ack),
    .busy    (busy)
  );

  led_bank_sched #(.NBANK(4), .W(4), .DWELL(3), .GAP(0)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .enable  (b_enable),
    .req     (b_req),
    .data    (b_data),
    .val_out (b_val),
    .bank_en (b_en),
    .grant   (b_grant),
    .ack     (b_ack),
    .busy    (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    req    = '0;
    data   = '0;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 0; req = 0; data = 0;
    b_enable = 0; b_req = 0; b_data = 0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({val_out, bank_en, grant, ack, busy} !== 17'd0) begin
      errors++;
      $display("FAIL reset_a got val=%h en=%b gr=%b ack=%b busy=%b want all 0",
               val_out, bank_en, grant, ack, busy);
    end
    checks++;
    if ({b_val, b_en, b_grant, b_ack, b_busy} !== 17'd0) begin
      errors++;
      $display("FAIL reset_b got val=%h en=%b ack=%b busy=%b want all 0",
               b_val, b_en, b_ack, b_busy);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    enable = 1; req = 4'b0001; data = 16'h000A;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if ({bank_en, grant, val_out, ack, busy} !== {4'b0001, 4'b0001, 4'hA, 4'b0, 1'b1}) begin
        errors++;
        $display("FAIL single_hold c=%0d got en=%b gr=%b val=%h ack=%b busy=%b want 0001 0001 a 0000 1",
                 c, bank_en, grant, val_out, ack, busy);
      end
    end
    tick();
    checks++;
    if ({ack, bank_en, val_out, busy} !== {4'b0001, 4'b0, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL single_ack got ack=%b en=%b val=%h busy=%b want 0001 0000 0 1",
               ack, bank_en, val_out, busy);
    end
    req = 0;
    tick();
    checks++;
    if ({ack, bank_en, busy} !== 9'd0) begin
      errors++;
      $display("FAIL single_idle got ack=%b en=%b busy=%b want 0000 0000 0",
               ack, bank_en, busy);
    end
  endtask

  task automatic test_all_req();
    logic [3:0] ge[5];
    logic [3:0] gv[5];
    int         gt[5];
    logic [3:0] xe[5];
    logic [3:0] xv[5];
    logic [3:0] prev;
    int         n;
    xe = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1};
    xv = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    n = 0;
    prev = '0;
    do_reset();
    enable = 1; req = 4'hF; data = 16'h4321;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (bank_en != 0 && prev == 0 && n < 5) begin
        ge[n] = bank_en; gv[n] = val_out; gt[n] = c; n++;
      end
      prev = bank_en;
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL all_count got %0d grants want 5", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (ge[i] !== xe[i] || gv[i] !== xv[i]) begin
        errors++;
        $display("FAIL all_order i=%0d got en=%b val=%h want en=%b val=%h",
                 i, ge[i], gv[i], xe[i], xv[i]);
      end
      if (i > 0) begin
        checks++;
        if (gt[i] - gt[i-1] != 10) begin
          errors++;
          $display("FAIL all_period i=%0d got %0d want 10", i, gt[i] - gt[i-1]);
        end
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    enable = 1; req = 4'b1100; data = 16'h9700;
    tick();
    checks++;
    if ({bank_en, val_out} !== {4'b0100, 4'h7}) begin
      errors++;
      $display("FAIL abort_grant got en=%b val=%h want 0100 7", bank_en, val_out);
    end
    tick();
    tick();
    req = 4'b1000;
    tick();
    checks++;
    if ({bank_en, val_out, ack, busy} !== {4'b0, 4'h0, 4'b0, 1'b1}) begin
      errors++;
      $display("FAIL abort_blank got en=%b val=%h ack=%b busy=%b want 0000 0 0000 1",
               bank_en, val_out, ack, busy);
    end
    tick();
    checks++;
    if ({ack, busy} !== 5'd0) begin
      errors++;
      $display("FAIL abort_idle got ack=%b busy=%b want 0000 0", ack, busy);
    end
    tick();
    checks++;
    if ({bank_en, val_out} !== {4'b1000, 4'h9}) begin
      errors++;
      $display("FAIL abort_next got en=%b val=%h want 1000 9", bank_en, val_out);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    enable = 1; req = 4'b0010; data = 16'h0050;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if ({bank_en, val_out} !== {4'b0010, 4'h5}) begin
        errors++;
        $display("FAIL freeze c=%0d got en=%b val=%h want 0010 5", c, bank_en, val_out);
      end
      if (c == 3) data = 16'h00F0;
    end
    tick();
    checks++;
    if (ack !== 4'b0010) begin
      errors++;
      $display("FAIL freeze_ack got %b want 0010", ack);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1; req = 4'b0001; data = 16'h00BA;
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({val_out, bank_en, grant, ack, busy} !== 17'd0) begin
      errors++;
      $display("FAIL async_clear got val=%h en=%b gr=%b ack=%b busy=%b want all 0",
               val_out, bank_en, grant, ack, busy);
    end
    req = 4'b0011;
    tick();
    checks++;
    if ({bank_en, ack, busy} !== 9'd0) begin
      errors++;
      $display("FAIL async_held got en=%b ack=%b busy=%b want 0", bank_en, ack, busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({bank_en, val_out, ack} !== {4'b0001, 4'hA, 4'b0}) begin
      errors++;
      $display("FAIL async_regrant got en=%b val=%h ack=%b want 0001 a 0000",
               bank_en, val_out, ack);
    end
  endtask

  task automatic test_gap0_enable();
    do_reset();
    b_enable = 1; b_req = 4'hF; b_data = 16'h8765;
    tick();
    checks++;
    if ({b_en, b_val} !== {4'b0001, 4'h5}) begin
      errors++;
      $display("FAIL gap0_first got en=%b val=%h want 0001 5", b_en, b_val);
    end
    tick();
    tick();
    tick();
    checks++;
    if ({b_ack, b_en, b_val, b_busy} !== {4'b0001, 4'b0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL gap0_ack got ack=%b en=%b val=%h busy=%b want 0001 0000 0 0",
               b_ack, b_en, b_val, b_busy);
    end
    tick();
    checks++;
    if ({b_en, b_val} !== {4'b0010, 4'h6}) begin
      errors++;
      $display("FAIL gap0_second got en=%b val=%h want 0010 6", b_en, b_val);
    end
    b_enable = 0;
    tick();
    checks++;
    if ({b_en, b_ack, b_busy} !== 9'd0) begin
      errors++;
      $display("FAIL gap0_abort got en=%b ack=%b busy=%b want 0", b_en, b_ack, b_busy);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({b_en, b_grant, b_busy} !== 9'd0) begin
        errors++;
        $display("FAIL gate_off c=%0d got en=%b gr=%b busy=%b want 0", c, b_en, b_grant, b_busy);
      end
    end
    b_enable = 1;
    tick();
    checks++;
    if ({b_en, b_val} !== {4'b0100, 4'h7}) begin
      errors++;
      $display("FAIL gate_on got en=%b val=%h want 0100 7", b_en, b_val);
    end
    b_enable = 0;
    b_req = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_all_req();
    test_abort();
    test_freeze();
    test_async_reset();
    test_gap0_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
